// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM request/response, redirect, and the
// valid/ready instruction stream towards decode.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] romAddr_Out;
  logic              romAddrValid_Out;
  logic [31:0]       romInstr_In;
  logic              romInstrValid_In;
  logic              redirect_In;
  logic [31:0]       redirectPc_In;
  logic [31:0]       instr_Out;
  logic [31:0]       instrPc_Out;
  logic              instrValid_Out;
  logic              instrReady_In;

  // Fetch stage side.
  modport master (
    output romAddr_Out, romAddrValid_Out,
    output instr_Out, instrPc_Out, instrValid_Out,
    input  romInstr_In, romInstrValid_In,
    input  redirect_In, redirectPc_In,
    input  instrReady_In
  );

  // ROM / decode / branch-unit side.
  modport slave (
    input  romAddr_Out, romAddrValid_Out,
    input  instr_Out, instrPc_Out, instrValid_Out,
    output romInstr_In, romInstrValid_In,
    output redirect_In, redirectPc_In,
    output instrReady_In
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a fixed 1-cycle-latency ROM.
// One read per cycle from the PC; responses land in a small {pc, instr}
// FIFO that feeds decode over valid/ready. Requests are only issued when a
// FIFO slot is guaranteed for the response (credit = count + in-flight),
// because the ROM cannot be stalled. A redirect flushes everything younger.
// BUF_DEPTH must be >= 2; RESET_PC must be word aligned.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          ADDR_W    = 16,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

  // Control state (reset)
  logic [31:0]      pc_q, pc_d;
  logic             req_pending_q, req_pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  // Data state (no reset)
  logic [31:0]      req_pc_q;
  logic [31:0]      pc_mem_q    [BUF_DEPTH];
  logic [31:0]      instr_mem_q [BUF_DEPTH];

  logic             head_vld;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;
  logic             unused_redirect_lsbs;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  assign unused_redirect_lsbs = ^bus.redirectPc_In[1:0];

  // ---- Stage 0: request issue (address is combinational from pc_q) ----
  assign head_vld  = ~rst & ~bus.redirect_In & (count_q != '0);
  assign pop       = head_vld & bus.instrReady_In;
  // Slots that will be occupied after this cycle if nothing new is issued.
  assign occupancy = {1'b0, count_q}
                   + {{CNT_W{1'b0}}, req_pending_q}
                   - {{CNT_W{1'b0}}, pop};
  assign issue     = ~rst & ~bus.redirect_In & (occupancy < DEPTH_C);

  assign bus.romAddr_Out      = pc_q[ADDR_W-1:0];
  assign bus.romAddrValid_Out = issue;

  // ---- Stage 1: ROM response capture into the FIFO ----
  // A response only counts if we actually asked for it last cycle and no
  // flush is happening now.
  assign push = ~rst & bus.romInstrValid_In & req_pending_q & ~bus.redirect_In;

  // ---- Stage 2: FIFO head presented to decode ----
  assign bus.instrValid_Out = head_vld;
  assign bus.instr_Out      = head_vld ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.instrPc_Out    = head_vld ? pc_mem_q[rd_ptr_q]    : '0;

  // Next-state for PC, in-flight flag and FIFO bookkeeping.
  always_comb begin
    pc_d          = pc_q;
    req_pending_d = issue;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (bus.redirect_In) begin
      pc_d     = {bus.redirectPc_In[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control registers; reset wins over redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pending_q <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      req_pending_q <= req_pending_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Remember which PC the outstanding ROM read belongs to.
  always_ff @(posedge clk) begin
    if (issue) begin
      req_pc_q <= pc_q;
    end
  end

  // FIFO storage write of {pc, instr}.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.romInstr_In;
    end
  end

  // Credit accounting must never let a ROM response land in a full buffer.
  assert property (@(posedge clk) disable iff (rst) !(push && (count_q == FULL_C)));

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios push expected PCs,
// a negedge monitor pops and compares every accepted instruction.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic inject_a;

  instr_fetch_if #(.ADDR_W(16)) bus_a ();
  instr_fetch_if #(.ADDR_W(16)) bus_b ();

  instr_fetch #(.RESET_PC(32'h0), .ADDR_W(16), .BUF_DEPTH(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  instr_fetch #(.RESET_PC(32'h0000FFFC), .ADDR_W(16), .BUF_DEPTH(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // ROM models: answer one cycle after each request; inject_a forces a
  // spurious response for the stale-data scenario.
  always @(posedge clk) begin
    bus_a.romInstrValid_In <= bus_a.romAddrValid_Out | inject_a;
    bus_a.romInstr_In      <= inject_a ? 32'hDEADBEEF : rom_fn(bus_a.romAddr_Out);
    bus_b.romInstrValid_In <= bus_b.romAddrValid_Out;
    bus_b.romInstr_In      <= rom_fn(bus_b.romAddr_Out);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake on the decode side is checked against the queue.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus_a.instrValid_Out === 1'b1 && bus_a.instrReady_In === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pop_a: got pc 0x%08h, required no output", bus_a.instrPc_Out);
      end else begin
        e = exp_a.pop_front();
        chk("pop_pc_a", bus_a.instrPc_Out, e);
        chk("pop_instr_a", bus_a.instr_Out, rom_fn(e[15:0]));
      end
    end
    if (bus_b.instrValid_Out === 1'b1 && bus_b.instrReady_In === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pop_b: got pc 0x%08h, required no output", bus_b.instrPc_Out);
      end else begin
        e = exp_b.pop_front();
        chk("pop_pc_b", bus_b.instrPc_Out, e);
        chk("pop_instr_b", bus_b.instr_Out, rom_fn(e[15:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    bus_a.instrReady_In = 1'b0;
    bus_a.redirect_In   = 1'b0;
    rst_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
  endtask

  task automatic drain(input int sel, input string nm);
    int k;
    int left;
    k = 0;
    left = (sel == 0) ? exp_a.size() : exp_b.size();
    while (left != 0 && k < 60) begin
      tick();
      k++;
      left = (sel == 0) ? exp_a.size() : exp_b.size();
    end
    if (left != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: %0d entries never output, required 0", nm, left);
      if (sel == 0) exp_a.delete(); else exp_b.delete();
    end
    if (sel == 0) bus_a.instrReady_In = 1'b0;
    else          bus_b.instrReady_In = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    int found;
    rst_a = 1'b1;
    rst_b = 1'b1;
    inject_a = 1'b0;
    bus_a.instrReady_In = 1'b0;
    bus_a.redirect_In   = 1'b0;
    bus_a.redirectPc_In = 32'h0;
    bus_b.instrReady_In = 1'b0;
    bus_b.redirect_In   = 1'b0;
    bus_b.redirectPc_In = 32'h0;

    // Scenario 1: reset state, then streaming from PC 0.
    tick();
    @(negedge clk);
    chk("rst_romAddrValid", 32'(bus_a.romAddrValid_Out), 32'd0);
    chk("rst_instrValid", 32'(bus_a.instrValid_Out), 32'd0);
    chk("rst_instr_zero", bus_a.instr_Out, 32'h0);
    chk("rst_instrPc_zero", bus_a.instrPc_Out, 32'h0);
    tick();
    rst_a = 1'b0;
    exp_a.push_back(32'h0); exp_a.push_back(32'h4);
    exp_a.push_back(32'h8); exp_a.push_back(32'hC);
    bus_a.instrReady_In = 1'b1;
    @(negedge clk);
    chk("t1_addr0_vld", 32'(bus_a.romAddrValid_Out), 32'd1);
    chk("t1_addr0", 32'(bus_a.romAddr_Out), 32'h0000);
    chk("t1_lat_c0", 32'(bus_a.instrValid_Out), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_addr1", 32'(bus_a.romAddr_Out), 32'h0004);
    chk("t1_lat_c1", 32'(bus_a.instrValid_Out), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_addr2", 32'(bus_a.romAddr_Out), 32'h0008);
    chk("t1_lat_c2", 32'(bus_a.instrValid_Out), 32'd1);
    drain(0, "t1");

    // Scenario 2: back-pressure caps requests at the buffer depth.
    reset_a();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.romAddrValid_Out === 1'b1) reqs++;
      if (i >= 3) chk("t2_hold_pc", bus_a.instrPc_Out, 32'h0);
      tick();
    end
    chk("t2_req_count", 32'(reqs), 32'd2);
    @(negedge clk);
    chk("t2_no_issue_full", 32'(bus_a.romAddrValid_Out), 32'd0);
    chk("t2_head_valid", 32'(bus_a.instrValid_Out), 32'd1);
    tick();
    exp_a.push_back(32'h0); exp_a.push_back(32'h4); exp_a.push_back(32'h8);
    bus_a.instrReady_In = 1'b1;
    drain(0, "t2");

    // Scenario 3: redirect while 0x10 is in flight.
    reset_a();
    exp_a.push_back(32'h0);   exp_a.push_back(32'h4);  exp_a.push_back(32'h8);
    exp_a.push_back(32'h100); exp_a.push_back(32'h104);
    bus_a.instrReady_In = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus_a.romAddrValid_Out === 1'b1 && bus_a.romAddr_Out === 16'h0010) found = 1;
      else tick();
    end
    chk("t3_saw_req_0x10", 32'(found), 32'd1);
    tick();
    bus_a.redirect_In   = 1'b1;
    bus_a.redirectPc_In = 32'h100;
    @(negedge clk);
    chk("t3_redir_no_valid", 32'(bus_a.instrValid_Out), 32'd0);
    chk("t3_redir_no_issue", 32'(bus_a.romAddrValid_Out), 32'd0);
    tick();
    bus_a.redirect_In = 1'b0;
    @(negedge clk);
    chk("t3_new_addr_vld", 32'(bus_a.romAddrValid_Out), 32'd1);
    chk("t3_new_addr", 32'(bus_a.romAddr_Out), 32'h0100);
    drain(0, "t3");

    // Scenario 4: misaligned redirect target is forced to word alignment.
    reset_a();
    bus_a.redirect_In   = 1'b1;
    bus_a.redirectPc_In = 32'h103;
    @(negedge clk);
    chk("t4_redir_no_issue", 32'(bus_a.romAddrValid_Out), 32'd0);
    tick();
    bus_a.redirect_In = 1'b0;
    @(negedge clk);
    chk("t4_addr_vld", 32'(bus_a.romAddrValid_Out), 32'd1);
    chk("t4_addr", 32'(bus_a.romAddr_Out), 32'h0100);
    tick();
    exp_a.push_back(32'h100); exp_a.push_back(32'h104);
    bus_a.instrReady_In = 1'b1;
    drain(0, "t4");

    // Scenario 5: reset pulse with a full buffer, stale response injected.
    reset_a();
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    chk("t5_full_valid", 32'(bus_a.instrValid_Out), 32'd1);
    tick();
    rst_a = 1'b1;
    inject_a = 1'b1;
    @(negedge clk);
    chk("t5_rst_no_valid", 32'(bus_a.instrValid_Out), 32'd0);
    chk("t5_rst_no_issue", 32'(bus_a.romAddrValid_Out), 32'd0);
    tick();
    rst_a = 1'b0;
    inject_a = 1'b0;
    @(negedge clk);
    chk("t5_after_rst_no_valid", 32'(bus_a.instrValid_Out), 32'd0);
    chk("t5_restart_addr", 32'(bus_a.romAddr_Out), 32'h0000);
    chk("t5_restart_vld", 32'(bus_a.romAddrValid_Out), 32'd1);
    tick();
    @(negedge clk);
    chk("t5_stale_not_pushed", 32'(bus_a.instrValid_Out), 32'd0);
    tick();
    exp_a.push_back(32'h0); exp_a.push_back(32'h4);
    bus_a.instrReady_In = 1'b1;
    drain(0, "t5");

    // Scenario 6: PC crossing the ROM address alias boundary.
    rst_b = 1'b0;
    exp_b.push_back(32'h0000FFFC); exp_b.push_back(32'h00010000); exp_b.push_back(32'h00010004);
    bus_b.instrReady_In = 1'b1;
    @(negedge clk);
    chk("t6_addr_fffc", 32'(bus_b.romAddr_Out), 32'h0000FFFC);
    tick();
    @(negedge clk);
    chk("t6_addr_wrap", 32'(bus_b.romAddr_Out), 32'h00000000);
    chk("t6_addr_wrap_vld", 32'(bus_b.romAddrValid_Out), 32'd1);
    drain(1, "t6");

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
